// File: rtl/mem_responder.sv
// mem_responder: executes byte/word CPU data accesses on an 8-bit async SRAM.
// A word is two little-endian byte phases; each phase lasts WAIT+1 cycles.
// All outputs come straight from flops.
module mem_responder #(
    parameter int unsigned WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        rd_mem,
    input  logic        wr_mem,
    input  logic        byt,
    output logic [15:0] rdata,
    output logic        rd_valid,
    output logic        busy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    output logic        mem_oe,
    output logic        mem_we
);

    localparam logic [3:0] WAIT_C = 4'(WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PH_LO = 2'd1,
        PH_HI = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic        byt_q, byt_d;
    logic [7:0]  whi_q, whi_d;
    logic [7:0]  rdata_lo_q, rdata_lo_d;
    logic [15:0] rdata_q, rdata_d;
    logic        rd_valid_q, rd_valid_d;
    logic        busy_q, busy_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_oe_q, mem_oe_d;
    logic        mem_we_q, mem_we_d;
    logic        last_s;
    logic [3:0]  cnt_inc_s;

    assign last_s    = (cnt_q == WAIT_C);
    assign cnt_inc_s = cnt_q + 4'd1;

    // Next-state and next-output logic for the access sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        byt_d      = byt_q;
        whi_d      = whi_q;
        rdata_lo_d = rdata_lo_q;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        busy_d     = busy_q;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        mem_oe_d   = mem_oe_q;
        mem_we_d   = mem_we_q;

        case (state_q)
            IDLE: begin
                if (rd_mem || wr_mem) begin
                    // A simultaneous read+write strobe is a write
                    state_d    = PH_LO;
                    busy_d     = 1'b1;
                    cnt_d      = 4'd0;
                    wr_d       = wr_mem;
                    byt_d      = byt;
                    whi_d      = wdata[15:8];
                    mem_addr_d = addr;
                    if (wr_mem) begin
                        mem_dout_d = wdata[7:0];
                    end else begin
                        mem_dout_d = mem_dout_q;
                    end
                    // WAIT >= 1, so counter 0 is always a write-strobe cycle
                    mem_oe_d   = ~wr_mem;
                    mem_we_d   = wr_mem;
                end else begin
                    state_d = IDLE;
                end
            end

            PH_LO: begin
                if (last_s) begin
                    if (!wr_q) begin
                        rdata_lo_d = mem_din;
                    end else begin
                        rdata_lo_d = rdata_lo_q;
                    end
                    if (!byt_q) begin
                        state_d    = PH_HI;
                        cnt_d      = 4'd0;
                        mem_addr_d = mem_addr_q + 16'd1;
                        if (wr_q) begin
                            mem_dout_d = whi_q;
                        end else begin
                            mem_dout_d = mem_dout_q;
                        end
                        mem_oe_d   = ~wr_q;
                        mem_we_d   = wr_q;
                    end else begin
                        state_d  = IDLE;
                        busy_d   = 1'b0;
                        mem_oe_d = 1'b0;
                        mem_we_d = 1'b0;
                        if (!wr_q) begin
                            rd_valid_d = 1'b1;
                            rdata_d    = {8'h00, mem_din};
                        end else begin
                            rd_valid_d = 1'b0;
                        end
                    end
                end else begin
                    // Drop the write strobe one cycle before the phase ends
                    cnt_d    = cnt_inc_s;
                    mem_we_d = wr_q && (cnt_inc_s < WAIT_C);
                end
            end

            PH_HI: begin
                if (last_s) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    mem_oe_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (!wr_q) begin
                        rd_valid_d = 1'b1;
                        rdata_d    = {mem_din, rdata_lo_q};
                    end else begin
                        rd_valid_d = 1'b0;
                    end
                end else begin
                    cnt_d    = cnt_inc_s;
                    mem_we_d = wr_q && (cnt_inc_s < WAIT_C);
                end
            end

            default: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                mem_oe_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            wr_q       <= 1'b0;
            byt_q      <= 1'b0;
            whi_q      <= 8'h00;
            rdata_lo_q <= 8'h00;
            rdata_q    <= 16'h0000;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            mem_addr_q <= 16'h0000;
            mem_dout_q <= 8'h00;
            mem_oe_q   <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            byt_q      <= byt_d;
            whi_q      <= whi_d;
            rdata_lo_q <= rdata_lo_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
            mem_oe_q   <= mem_oe_d;
            mem_we_q   <= mem_we_d;
        end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign mem_addr = mem_addr_q;
    assign mem_dout = mem_dout_q;
    assign mem_oe   = mem_oe_q;
    assign mem_we   = mem_we_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: WAIT=1 instance (A) driven with directed and
// random transactions, WAIT=3 instance (B) for the long-phase case.
// Expected data comes from a byte-array memory model updated per transaction.
module tb_mem_responder;

    localparam int WAIT_A = 1;
    localparam int L_A    = WAIT_A + 1;
    localparam int WAIT_B = 3;
    localparam int L_B    = WAIT_B + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [15:0] addr = 16'h0, wdata = 16'h0;
    logic        rd_mem = 1'b0, wr_mem = 1'b0, byt = 1'b0;
    logic [15:0] rdata, mem_addr;
    logic        rd_valid, busy, mem_oe, mem_we;
    logic [7:0]  mem_dout, mem_din;

    logic [15:0] b_addr = 16'h0, b_wdata = 16'h0;
    logic        b_rd_mem = 1'b0, b_wr_mem = 1'b0, b_byt = 1'b0;
    logic [15:0] b_rdata, b_mem_addr;
    logic        b_rd_valid, b_busy, b_mem_oe, b_mem_we;
    logic [7:0]  b_mem_dout, b_mem_din;

    logic [7:0]  sram_a  [0:65535];
    logic [7:0]  sram_b  [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] exp_rdata;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT(WAIT_A)) dut_a (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rd_mem(rd_mem),
        .wr_mem(wr_mem), .byt(byt), .rdata(rdata), .rd_valid(rd_valid),
        .busy(busy), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_oe(mem_oe), .mem_we(mem_we)
    );

    mem_responder #(.WAIT(WAIT_B)) dut_b (
        .clk(clk), .rst(rst), .addr(b_addr), .wdata(b_wdata), .rd_mem(b_rd_mem),
        .wr_mem(b_wr_mem), .byt(b_byt), .rdata(b_rdata), .rd_valid(b_rd_valid),
        .busy(b_busy), .mem_addr(b_mem_addr), .mem_dout(b_mem_dout),
        .mem_din(b_mem_din), .mem_oe(b_mem_oe), .mem_we(b_mem_we)
    );

    // Asynchronous SRAM models: combinational read, write while mem_we is high
    assign mem_din   = sram_a[mem_addr];
    assign b_mem_din = sram_b[b_mem_addr];
    always @(posedge clk) if (mem_we) sram_a[mem_addr] <= mem_dout;
    always @(posedge clk) if (b_mem_we) sram_b[b_mem_addr] <= b_mem_dout;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction on instance A, checked cycle by cycle from cycle 1 to
    // the completion cycle; returns in the completion cycle (busy = 0).
    task automatic txn(input bit wr, input bit bw, input logic [15:0] a,
                       input logic [15:0] wd, input bit both, input bit spur);
        int          total;
        int          p;
        int          c;
        bit          ph;
        logic [15:0] a1;
        logic [15:0] prev;
        logic [15:0] e_addr;
        logic [7:0]  e_dout;
        total = (bw ? 1 : 2) * L_A;
        a1    = a + 16'd1;
        prev  = exp_rdata;
        if (wr) begin
            ref_mem[a] = wd[7:0];
            if (!bw) ref_mem[a1] = wd[15:8];
        end else begin
            exp_rdata = bw ? {8'h00, ref_mem[a]} : {ref_mem[a1], ref_mem[a]};
        end
        rd_mem = !wr || both;
        wr_mem = wr;
        byt    = bw;
        addr   = a;
        wdata  = wd;
        step();
        rd_mem = 1'b0;
        wr_mem = 1'b0;
        addr   = 16'($urandom);
        wdata  = 16'($urandom);
        byt    = 1'($urandom);
        for (int k = 1; k <= total + 1; k++) begin
            if (k > 1) step();
            ph     = (k <= total);
            p      = (k - 1) / L_A;
            c      = (k - 1) % L_A;
            e_addr = a + 16'(p);
            e_dout = (p == 1) ? wd[15:8] : wd[7:0];
            vectors++;
            if (busy !== ph) begin
                miscompares++;
                $display("FAIL busy a=%h k=%0d got %b exp %b", a, k, busy, ph);
            end
            vectors++;
            if (rd_valid !== (!ph && !wr)) begin
                miscompares++;
                $display("FAIL rd_valid a=%h k=%0d got %b exp %b", a, k, rd_valid, !ph && !wr);
            end
            vectors++;
            if (mem_oe !== (ph && !wr)) begin
                miscompares++;
                $display("FAIL mem_oe a=%h k=%0d got %b exp %b", a, k, mem_oe, ph && !wr);
            end
            vectors++;
            if (mem_we !== (ph && wr && c < WAIT_A)) begin
                miscompares++;
                $display("FAIL mem_we a=%h k=%0d got %b exp %b", a, k, mem_we, ph && wr && c < WAIT_A);
            end
            if (ph) begin
                vectors++;
                if (mem_addr !== e_addr) begin
                    miscompares++;
                    $display("FAIL mem_addr a=%h k=%0d got %h exp %h", a, k, mem_addr, e_addr);
                end
                if (wr) begin
                    vectors++;
                    if (mem_dout !== e_dout) begin
                        miscompares++;
                        $display("FAIL mem_dout a=%h k=%0d got %h exp %h", a, k, mem_dout, e_dout);
                    end
                end
            end
            vectors++;
            if (rdata !== (ph ? prev : exp_rdata)) begin
                miscompares++;
                $display("FAIL rdata a=%h k=%0d got %h exp %h", a, k, rdata, ph ? prev : exp_rdata);
            end
            if (spur && k == 2) rd_mem = 1'b1;
            if (spur && k == 3) rd_mem = 1'b0;
        end
        if (wr) begin
            vectors++;
            if (sram_a[a] !== ref_mem[a] || sram_a[a1] !== ref_mem[a1]) begin
                miscompares++;
                $display("FAIL sram a=%h got %h%h exp %h%h", a, sram_a[a1], sram_a[a],
                         ref_mem[a1], ref_mem[a]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        vectors++;
        if ({busy, rd_valid, mem_oe, mem_we, b_busy, b_rd_valid} !== 6'b0 ||
            rdata !== 16'h0 || mem_addr !== 16'h0 || mem_dout !== 8'h0) begin
            miscompares++;
            $display("FAIL reset got busy=%b rv=%b oe=%b we=%b rdata=%h addr=%h dout=%h exp all zero",
                     busy, rd_valid, mem_oe, mem_we, rdata, mem_addr, mem_dout);
        end
        rst = 1'b1;
        exp_rdata = 16'h0;
        step();
    endtask

    task automatic test_word_read();
        sram_a[16'h0100] = 8'h34; ref_mem[16'h0100] = 8'h34;
        sram_a[16'h0101] = 8'h12; ref_mem[16'h0101] = 8'h12;
        txn(1'b0, 1'b0, 16'h0100, 16'h0, 1'b0, 1'b0);
        vectors++;
        if (rdata !== 16'h1234) begin
            miscompares++;
            $display("FAIL word_read got %h exp 1234", rdata);
        end
        step();
    endtask

    task automatic test_byte_wr_rd();
        txn(1'b1, 1'b1, 16'h0200, 16'hABCD, 1'b0, 1'b0);
        step();
        txn(1'b0, 1'b1, 16'h0200, 16'h0, 1'b0, 1'b0);
        vectors++;
        if (rdata !== 16'h00CD) begin
            miscompares++;
            $display("FAIL byte_rd got %h exp 00cd", rdata);
        end
        step();
    endtask

    task automatic test_wrap_write();
        txn(1'b1, 1'b0, 16'hFFFF, 16'hBEEF, 1'b1, 1'b0);
        vectors++;
        if (sram_a[16'hFFFF] !== 8'hEF || sram_a[16'h0000] !== 8'hBE) begin
            miscompares++;
            $display("FAIL wrap got ffff=%h 0000=%h exp ef be", sram_a[16'hFFFF], sram_a[16'h0000]);
        end
        step();
    endtask

    task automatic test_back_to_back();
        txn(1'b0, 1'b0, 16'h0100, 16'h0, 1'b0, 1'b1);
        step();
        vectors++;
        if (busy !== 1'b0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_strobe got busy=%b rv=%b exp 0 0", busy, rd_valid);
        end
        txn(1'b0, 1'b0, 16'h0200, 16'h0, 1'b0, 1'b0);
        txn(1'b0, 1'b0, 16'hFFFF, 16'h0, 1'b0, 1'b0);
        txn(1'b1, 1'b1, 16'h0300, 16'h1177, 1'b0, 1'b0);
        txn(1'b0, 1'b1, 16'h0300, 16'h0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_reset_mid();
        wr_mem = 1'b1; byt = 1'b0; addr = 16'h0400; wdata = 16'h6655;
        ref_mem[16'h0400] = 8'h55;
        step();
        wr_mem = 1'b0;
        for (int k = 2; k <= L_A + 1; k++) step();
        vectors++;
        if (busy !== 1'b1 || mem_addr !== 16'h0401) begin
            miscompares++;
            $display("FAIL mid_pre got busy=%b addr=%h exp 1 0401", busy, mem_addr);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy, mem_we, mem_oe, rd_valid} !== 4'b0 || rdata !== 16'h0) begin
            miscompares++;
            $display("FAIL mid_reset got busy=%b we=%b oe=%b rv=%b rdata=%h exp zeros",
                     busy, mem_we, mem_oe, rd_valid, rdata);
        end
        exp_rdata = 16'h0;
        step();
        rst = 1'b1;
        step();
        vectors++;
        if (busy !== 1'b0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_idle got busy=%b rv=%b exp 0 0", busy, rd_valid);
        end
        txn(1'b0, 1'b0, 16'h0100, 16'h0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_wait3();
        logic [15:0] exp_b;
        for (int t = 0; t < 2; t++) begin
            b_wr_mem = (t == 0); b_rd_mem = (t == 1); b_byt = 1'b0;
            b_addr = 16'h1234; b_wdata = 16'h5A3C;
            step();
            b_wr_mem = 1'b0; b_rd_mem = 1'b0; b_addr = 16'h0; b_wdata = 16'h0;
            for (int k = 1; k <= 2 * L_B + 1; k++) begin
                if (k > 1) step();
                vectors++;
                if (b_busy !== (k <= 2 * L_B)) begin
                    miscompares++;
                    $display("FAIL w3_busy t=%0d k=%0d got %b exp %b", t, k, b_busy, k <= 2 * L_B);
                end
                vectors++;
                if (b_rd_valid !== (t == 1 && k == 2 * L_B + 1)) begin
                    miscompares++;
                    $display("FAIL w3_rd_valid t=%0d k=%0d got %b exp %b", t, k, b_rd_valid,
                             t == 1 && k == 2 * L_B + 1);
                end
                vectors++;
                if (b_mem_oe === 1'b1 && b_mem_we === 1'b1) begin
                    miscompares++;
                    $display("FAIL w3_overlap t=%0d k=%0d got oe=1 we=1 exp not both", t, k);
                end
                vectors++;
                if (b_mem_we !== (t == 0 && k <= 2 * L_B && ((k - 1) % L_B) < WAIT_B)) begin
                    miscompares++;
                    $display("FAIL w3_we t=%0d k=%0d got %b", t, k, b_mem_we);
                end
            end
            exp_b = 16'h5A3C;
            if (t == 1) begin
                vectors++;
                if (b_rdata !== exp_b) begin
                    miscompares++;
                    $display("FAIL w3_rdata got %h exp %h", b_rdata, exp_b);
                end
            end
        end
        step();
    endtask

    task automatic test_random();
        logic [15:0] a;
        bit          wr;
        bit          bw;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0:       a = 16'hFFFF;
                1:       a = 16'hFFF8 + 16'($urandom_range(0, 7));
                default: a = 16'h0500 + 16'($urandom_range(0, 7));
            endcase
            wr = 1'($urandom);
            bw = 1'($urandom);
            txn(wr, bw, a, 16'($urandom), 1'($urandom), 1'($urandom));
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            sram_a[i]  = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
            sram_b[i]  = 8'(i);
        end
        exp_rdata = 16'h0;
        test_reset();
        test_word_read();
        test_byte_wr_rd();
        test_wrap_write();
        test_back_to_back();
        test_reset_mid();
        test_wait3();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's data-memory strobes. It accepts one `rd_mem`/`wr_mem` request per transaction, with `byt` selecting byte or 16-bit word width, and executes it on an external 8-bit asynchronous SRAM. A word takes two byte phases, little-endian; a byte takes one. It sits between the CPU core and the SRAM pins, returns read data with a `rd_valid` pulse, and holds `busy` high until the access completes so the core can stall.

## Interface
- `WAIT`, default 1: extra cycles per byte phase. Legal range is 1..15. Each byte phase lasts L = WAIT+1 cycles.
- `clk  in  1`: sole clock; all state changes on the rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `addr  in  16`: byte address of the request.
- `wdata  in  16`: write data; byte writes use `[7:0]`.
- `rd_mem  in  1`: read request strobe.
- `wr_mem  in  1`: write request strobe.
- `byt  in  1`: 1 = byte access, 0 = word access.
- `rdata  out  16`: read result; zero-extended for byte reads.
- `rd_valid  out  1`: one-cycle pulse when `rdata` is updated.
- `busy  out  1`: high while a transaction is in progress.
- `mem_addr  out  16`: SRAM byte address.
- `mem_dout  out  8`: SRAM write data.
- `mem_din  in  8`: SRAM read data.
- `mem_oe  out  1`: SRAM output enable, active-high.
- `mem_we  out  1`: SRAM write enable, active-high.

## Operation
- **Reset values.** When `rst` is 0, all registers clear asynchronously:
  - state = IDLE;
  - `busy`, `rd_valid`, `mem_oe`, `mem_we` = 0;
  - `rdata`, `mem_addr`, `mem_dout` = 0.
- **Reset mid-transaction.** Reset during any state aborts the access immediately. No partial `rd_valid` is issued.
- **State machine: IDLE → PH_LO → (PH_HI) → IDLE.**
- **IDLE, request accepted.** If `rd_mem | wr_mem` on a rising edge:
  - latch `addr`, `wdata`, `byt`, direction;
  - `busy` ← 1, state ← PH_LO;
  - wait counter ← 0.
- **Simultaneous strobes.** `rd_mem & wr_mem` together is treated as a write.
- **Strobes while busy.** `rd_mem`/`wr_mem` while `busy` = 1 are ignored. They are not queued.
- **PH_LO.**
  - `mem_addr` = latched addr.
  - Write: `mem_dout` = wdata[7:0].
  - The counter runs 0..WAIT. On the edge where counter = WAIT:
    - read: capture `mem_din` into rdata_lo;
    - go to PH_HI for a word, else finish.
- **PH_HI.**
  - `mem_addr` = addr + 1, computed modulo 2^16 (0xFFFF wraps to 0x0000).
  - Write: `mem_dout` = wdata[15:8].
  - Same counter behaviour. On the final edge: read captures `mem_din` into rdata_hi, then finish.
- **Finish.**
  - state ← IDLE, `busy` ← 0.
  - Read: also `rd_valid` ← 1 for exactly one cycle, and `rdata` ← {rdata_hi, rdata_lo} for a word or {8'h00, rdata_lo} for a byte.
  - Write: `rd_valid` stays 0 and `rdata` is unchanged.
- **SRAM strobes.**
  - `mem_oe` = 1 throughout every read phase.
  - `mem_we` = 1 for counter 0..WAIT-1 of each write phase and 0 on the last cycle. This gives address/data hold before the address changes.
  - `mem_oe` and `mem_we` are never 1 together.
- **Registered outputs.** All outputs are registered (no combinational input-to-output path).
- **Read data retention.** `rdata` holds its value until the next completed read.
- **Odd word addresses.** Legal: the low byte goes to `addr`, the high byte to `addr+1`.

## Timing
- Let cycle 0 be the cycle in which the request is sampled.
- `busy` = 1 from cycle 1 through cycle L (byte) or cycle 2L (word).
- Phase cycles: PH_LO occupies cycles 1..L; PH_HI occupies cycles L+1..2L.
- Completion cycle: `rd_valid` = 1 and `busy` = 0 in cycle L+1 (byte) or 2L+1 (word).
- Read latency, request to `rd_valid`: L+1 cycles (byte), 2L+1 cycles (word). With WAIT=1 this is 3 and 5 cycles.
- Back-to-back requests: a new request may be sampled in the completion cycle (`busy` = 0). That is the maximum throughput.
- SRAM sampling: `mem_din` is sampled at the end of the last cycle of each read phase. The SRAM must be valid within L cycles of the address change.
- `mem_addr`/`mem_dout` change only at phase boundaries, always with `mem_we` = 0 in the preceding cycle.

## Test plan
- **Word read.** WAIT=1; SRAM[0x0100]=0x34, [0x0101]=0x12; `rd_mem`, `byt`=0, addr=0x0100. Required response:
  - `busy` high in cycles 1–4;
  - `mem_addr` = 0x0100 in cycles 1–2, then 0x0101 in cycles 3–4;
  - `rd_valid` in cycle 5 with `rdata` = 0x1234.
- **Byte write, then byte read.** Byte write of wdata=0xABCD to 0x0200 → only [0x0200]=0xCD; `mem_we` high in cycle 1 only. A following byte read of 0x0200 → `rdata` = 0x00CD in cycle 3.
- **Word write with address wrap.** Word write 0xBEEF to 0xFFFF → [0xFFFF]=0xEF and [0x0000]=0xBE. `rd_valid` never asserts.
- **Ignored strobe and back-to-back.** A `rd_mem` issued during cycle 2 of a busy word read is ignored (only one `rd_valid`). A new read in the completion cycle is accepted, and its `rd_valid` arrives 5 cycles later.
- **Reset mid-access.** `rst` = 0 during PH_HI of a word write → same-cycle `busy`/`mem_we`/`mem_oe` = 0 and state IDLE. After release, a fresh read completes normally.
- **WAIT=3 word read.** `busy` = 1 for 8 cycles, `rd_valid` in cycle 9, and `mem_oe` never overlaps `mem_we`.
